// File: rtl/wbi_pkg.sv
// wbi_pkg: definitions shared by the interconnect node pair
// (wbi_master_node / wbi_slave_node).
//   - state_e : master-node sequencer states
//   - cmd_t   : command channel field layout (CFW bits wide)
//   - rsp_t   : response channel field layout (RFW bits wide)
//   - TID_W   : transaction-ID width
package wbi_pkg;

  localparam int TID_W  = 4;
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  localparam int CMD_BW = 4;
  localparam int CMD_BL = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_RD_DRAIN
  } state_e;

  typedef struct packed {
    logic [CMD_AW-1:0] adr;
    logic              we;
    logic [CMD_DW-1:0] dat;
    logic [CMD_BW-1:0] sel;
    logic [TID_W-1:0]  tid;
    logic [CMD_BL-1:0] bl;
  } cmd_t;

  localparam int CFW = $bits(cmd_t);

  typedef struct packed {
    logic [CMD_DW-1:0] dat;
    logic              lack;
    logic              err;
    logic [TID_W-1:0]  tid;
  } rsp_t;

  localparam int RFW = $bits(rsp_t);

endpackage

// File: rtl/wbi_master_node_if.sv
// Bus interfaces of wbi_master_node. Signal suffixes (_i/_o) are from the
// node's point of view.
//   wbi_wbm_if : Wishbone burst master side.
//                modport master = bus master (CPU/DMA/cache)
//                modport slave  = the node
//   wbi_wbc_if : command/response valid-ready channel.
//                modport master = the node
//                modport slave  = fabric / wbi_slave_node
interface wbi_wbm_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 4,
  parameter int BL = 10
);
  logic          wbm_cyc_i;
  logic          wbm_stb_i;
  logic [AW-1:0] wbm_adr_i;
  logic          wbm_we_i;
  logic [DW-1:0] wbm_dat_i;
  logic [BW-1:0] wbm_sel_i;
  logic [BL-1:0] wbm_bl_i;
  logic          wbm_bry_i;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_ack_o;
  logic          wbm_lack_o;
  logic          wbm_err_o;

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_adr_i, wbm_we_i, wbm_dat_i,
           wbm_sel_i, wbm_bl_i, wbm_bry_i,
    input  wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o
  );

  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_adr_i, wbm_we_i, wbm_dat_i,
           wbm_sel_i, wbm_bl_i, wbm_bry_i,
    output wbm_dat_o, wbm_ack_o, wbm_lack_o, wbm_err_o
  );
endinterface

interface wbi_wbc_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BW    = 4,
  parameter int BL    = 10,
  parameter int TID_W = 4
);
  logic             wbc_cmd_wrdy_i;
  logic             wbc_cmd_val_o;
  logic [AW-1:0]    wbc_cmd_adr_o;
  logic             wbc_cmd_we_o;
  logic [DW-1:0]    wbc_cmd_dat_o;
  logic [BW-1:0]    wbc_cmd_sel_o;
  logic [TID_W-1:0] wbc_cmd_tid_o;
  logic [BL-1:0]    wbc_cmd_bl_o;
  logic             wbc_res_rrdy_o;
  logic             wbc_res_rval_i;
  logic [DW-1:0]    wbc_res_dat_i;
  logic             wbc_res_lack_i;
  logic             wbc_res_err_i;
  logic [TID_W-1:0] wbc_res_tid_i;

  modport master (
    input  wbc_cmd_wrdy_i, wbc_res_rval_i, wbc_res_dat_i, wbc_res_lack_i,
           wbc_res_err_i, wbc_res_tid_i,
    output wbc_cmd_val_o, wbc_cmd_adr_o, wbc_cmd_we_o, wbc_cmd_dat_o,
           wbc_cmd_sel_o, wbc_cmd_tid_o, wbc_cmd_bl_o, wbc_res_rrdy_o
  );

  modport slave (
    output wbc_cmd_wrdy_i, wbc_res_rval_i, wbc_res_dat_i, wbc_res_lack_i,
           wbc_res_err_i, wbc_res_tid_i,
    input  wbc_cmd_val_o, wbc_cmd_adr_o, wbc_cmd_we_o, wbc_cmd_dat_o,
           wbc_cmd_sel_o, wbc_cmd_tid_o, wbc_cmd_bl_o, wbc_res_rrdy_o
  );
endinterface

// File: rtl/wbi_master_node.sv
// wbi_master_node: initiator-side bridge from a Wishbone burst master to the
// command/response valid-ready channel of wbi_slave_node.
//   clk_i, rst_n : clock, asynchronous active-low reset
//   wbm          : Wishbone burst master port (wbi_wbm_if.slave)
//   wbc          : command/response channel    (wbi_wbc_if.master)
// Writes are posted, one command per beat, acked in the handshake cycle.
// Reads issue one command, then return the response beats to the master.
module wbi_master_node
  import wbi_pkg::*;
#(
  parameter int               AW  = 32,
  parameter int               DW  = 32,
  parameter int               BW  = 4,
  parameter int               BL  = 10,
  parameter logic [TID_W-1:0] TID = 4'h0
) (
  input  logic      clk_i,
  input  logic      rst_n,
  wbi_wbm_if.slave  wbm,
  wbi_wbc_if.master wbc
);

  state_e        state_q, state_d;
  logic [BL:0]   cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [BL-1:0] bl_q, bl_d;

  logic [BL-1:0]    bl_eff;
  logic             rsp_err;
  logic             cmd_val;
  logic [AW-1:0]    cmd_adr;
  logic             cmd_we;
  logic [DW-1:0]    cmd_dat;
  logic [BW-1:0]    cmd_sel;
  logic [TID_W-1:0] cmd_tid;
  logic [BL-1:0]    cmd_bl;
  logic             res_rrdy;
  logic [DW-1:0]    m_dat;
  logic             m_ack;
  logic             m_lack;
  logic             m_err;

  // A burst count of zero is treated as a single beat.
  assign bl_eff  = (wbm.wbm_bl_i == '0) ? BL'(1) : wbm.wbm_bl_i;
  // A response carrying someone else's ID is reported as an error.
  assign rsp_err = wbc.wbc_res_err_i | (wbc.wbc_res_tid_i != TID);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      bl_q    <= bl_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    bl_d     = bl_q;
    cmd_val  = 1'b0;
    cmd_adr  = '0;
    cmd_we   = 1'b0;
    cmd_dat  = '0;
    cmd_sel  = '0;
    cmd_tid  = '0;
    cmd_bl   = '0;
    res_rrdy = 1'b0;
    m_dat    = '0;
    m_ack    = 1'b0;
    m_lack   = 1'b0;
    m_err    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wbm.wbm_cyc_i && wbm.wbm_stb_i && wbm.wbm_we_i && wbm.wbm_bry_i) begin
          // First write beat goes straight out; ack follows the handshake.
          cmd_val = 1'b1;
          cmd_adr = wbm.wbm_adr_i;
          cmd_we  = 1'b1;
          cmd_dat = wbm.wbm_dat_i;
          cmd_sel = wbm.wbm_sel_i;
          cmd_tid = TID;
          cmd_bl  = bl_eff;
          if (wbc.wbc_cmd_wrdy_i) begin
            m_ack = 1'b1;
            cnt_d = (BL+1)'(1);
            adr_d = wbm.wbm_adr_i;
            bl_d  = bl_eff;
            if (bl_eff == BL'(1)) begin
              m_lack = 1'b1;
            end else begin
              state_d = ST_WR_BURST;
            end
          end
        end else if (wbm.wbm_cyc_i && wbm.wbm_stb_i && !wbm.wbm_we_i) begin
          // Latch the read request so the command stays stable until taken.
          adr_d   = wbm.wbm_adr_i;
          bl_d    = bl_eff;
          state_d = ST_RD_CMD;
        end
      end

      ST_WR_BURST: begin
        if (!wbm.wbm_cyc_i) begin
          // Aborted burst: beats already posted are not recalled.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (wbm.wbm_stb_i && wbm.wbm_bry_i) begin
          // Address and count stay those of the first beat.
          cmd_val = 1'b1;
          cmd_adr = adr_q;
          cmd_we  = 1'b1;
          cmd_dat = wbm.wbm_dat_i;
          cmd_sel = wbm.wbm_sel_i;
          cmd_tid = TID;
          cmd_bl  = bl_q;
          if (wbc.wbc_cmd_wrdy_i) begin
            m_ack = 1'b1;
            cnt_d = cnt_q + (BL+1)'(1);
            if (cnt_d == {1'b0, bl_q}) begin
              m_lack  = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_RD_CMD: begin
        cmd_val = 1'b1;
        cmd_adr = adr_q;
        cmd_tid = TID;
        cmd_bl  = bl_q;
        cnt_d   = '0;
        if (wbc.wbc_cmd_wrdy_i) begin
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (!wbm.wbm_cyc_i) begin
          state_d = ST_RD_DRAIN;
        end else begin
          res_rrdy = wbm.wbm_bry_i;
          if (wbc.wbc_res_rval_i && wbm.wbm_bry_i) begin
            // An error terminates the burst, so it is flagged as last too.
            m_ack  = 1'b1;
            m_dat  = wbc.wbc_res_dat_i;
            m_err  = rsp_err;
            m_lack = wbc.wbc_res_lack_i | rsp_err;
            if (m_lack) begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_RD_DRAIN: begin
        // Swallow the rest of an abandoned read; the master sees nothing.
        res_rrdy = 1'b1;
        if (wbc.wbc_res_rval_i && wbc.wbc_res_lack_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are combinational from live inputs, so they must be forced
    // quiet while reset is held.
    if (!rst_n) begin
      cmd_val  = 1'b0;
      cmd_adr  = '0;
      cmd_we   = 1'b0;
      cmd_dat  = '0;
      cmd_sel  = '0;
      cmd_tid  = '0;
      cmd_bl   = '0;
      res_rrdy = 1'b0;
      m_dat    = '0;
      m_ack    = 1'b0;
      m_lack   = 1'b0;
      m_err    = 1'b0;
    end
  end

  assign wbc.wbc_cmd_val_o  = cmd_val;
  assign wbc.wbc_cmd_adr_o  = cmd_adr;
  assign wbc.wbc_cmd_we_o   = cmd_we;
  assign wbc.wbc_cmd_dat_o  = cmd_dat;
  assign wbc.wbc_cmd_sel_o  = cmd_sel;
  assign wbc.wbc_cmd_tid_o  = cmd_tid;
  assign wbc.wbc_cmd_bl_o   = cmd_bl;
  assign wbc.wbc_res_rrdy_o = res_rrdy;
  assign wbm.wbm_dat_o      = m_dat;
  assign wbm.wbm_ack_o      = m_ack;
  assign wbm.wbm_lack_o     = m_lack;
  assign wbm.wbm_err_o      = m_err;

endmodule

// File: tb/tb_wbi_master_node.sv
// tb_wbi_master_node: self-checking bench for wbi_master_node. The bench acts
// as both the Wishbone master and the channel fabric; expectations come from
// transaction-level rules (one command per write beat, one command per read,
// BL response beats returned in order, error ends the burst).
module tb_wbi_master_node;
  import wbi_pkg::*;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          BW  = 4;
  localparam int          BL  = 10;
  localparam logic [3:0]  TID = 4'h0;
  localparam logic [31:0] DRAIN_ADR = 32'h0000_6100;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  wbi_wbm_if #(.AW(AW), .DW(DW), .BW(BW), .BL(BL)) wbm_bus ();
  wbi_wbc_if #(.AW(AW), .DW(DW), .BW(BW), .BL(BL), .TID_W(4)) wbc_bus ();

  wbi_master_node #(.AW(AW), .DW(DW), .BW(BW), .BL(BL), .TID(TID)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .wbm   (wbm_bus),
    .wbc   (wbc_bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [9:0] bl, input logic bry);
    wbm_bus.wbm_cyc_i = cyc;
    wbm_bus.wbm_stb_i = stb;
    wbm_bus.wbm_we_i  = we;
    wbm_bus.wbm_adr_i = adr;
    wbm_bus.wbm_dat_i = dat;
    wbm_bus.wbm_sel_i = sel;
    wbm_bus.wbm_bl_i  = bl;
    wbm_bus.wbm_bry_i = bry;
  endtask

  task automatic idle_bus();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 10'h0, 1'b0);
    wbc_bus.wbc_cmd_wrdy_i = 1'b0;
    wbc_bus.wbc_res_rval_i = 1'b0;
    wbc_bus.wbc_res_dat_i  = 32'h0;
    wbc_bus.wbc_res_lack_i = 1'b0;
    wbc_bus.wbc_res_err_i  = 1'b0;
    wbc_bus.wbc_res_tid_i  = TID;
  endtask

  task automatic step_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput(tag, 64'({wbc_bus.wbc_cmd_val_o, wbc_bus.wbc_res_rrdy_o, wbm_bus.wbm_ack_o,
                          wbm_bus.wbm_lack_o, wbm_bus.wbm_err_o}), 64'h0);
    checkOutput({tag, "_dat"}, 64'(wbm_bus.wbm_dat_o), 64'h0);
  endtask

  // mode 0: always ready; 1: random bry/wrdy; 2: wrdy stalls 3 cycles on stall_beat
  task automatic do_write(input logic [31:0] adr, input logic [9:0] bl, input int mode,
                          input int stall_beat, input int abort_after);
    int          bl_eff, beat, cycles, stall, cmds;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        bry, wrdy;
    bl_eff = (bl == 10'd0) ? 1 : int'(bl);
    beat = 0; cycles = 0; stall = 0; cmds = 0;
    dat = $urandom;
    sel = 4'($urandom);
    while (beat < bl_eff && cycles < 300 && !(abort_after > 0 && beat == abort_after)) begin
      bry  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      wrdy = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mode == 2 && beat == stall_beat && stall < 3) begin
        wrdy = 1'b0;
        stall++;
      end
      // The master presents an incrementing address; commands must keep the start address.
      applyStimulus(1'b1, 1'b1, 1'b1, adr + 32'(beat * 4), dat, sel, bl, bry);
      wbc_bus.wbc_cmd_wrdy_i = wrdy;
      @(negedge clk_i);
      checkOutput("wr_val", 64'(wbc_bus.wbc_cmd_val_o), 64'(bry));
      if (wbc_bus.wbc_cmd_val_o && wrdy) begin
        checkOutput("wr_adr", 64'(wbc_bus.wbc_cmd_adr_o), 64'(adr));
        checkOutput("wr_we", 64'(wbc_bus.wbc_cmd_we_o), 64'd1);
        checkOutput("wr_dat", 64'(wbc_bus.wbc_cmd_dat_o), 64'(dat));
        checkOutput("wr_sel", 64'(wbc_bus.wbc_cmd_sel_o), 64'(sel));
        checkOutput("wr_tid", 64'(wbc_bus.wbc_cmd_tid_o), 64'(TID));
        checkOutput("wr_bl", 64'(wbc_bus.wbc_cmd_bl_o), 64'(bl_eff));
        checkOutput("wr_ack", 64'(wbm_bus.wbm_ack_o), 64'd1);
        checkOutput("wr_lack", 64'(wbm_bus.wbm_lack_o), 64'(beat == bl_eff - 1));
        checkOutput("wr_err", 64'(wbm_bus.wbm_err_o), 64'd0);
        cmds++;
        beat++;
        dat = $urandom;
        sel = 4'($urandom);
      end else begin
        checkOutput("wr_noack", 64'({wbm_bus.wbm_ack_o, wbm_bus.wbm_lack_o}), 64'd0);
      end
      step_cycle();
      cycles++;
    end
    if (cycles >= 300) checkOutput("wr_timeout", 64'd1, 64'd0);
    idle_bus();
    @(negedge clk_i);
    check_quiet("wr_end");
    checkOutput("wr_cmds", 64'(cmds), 64'((abort_after > 0) ? abort_after : bl_eff));
    step_cycle();
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [9:0] bl, input logic [31:0] base,
                         input int err_beat, input int tid_beat, input int drop_after, input bit rand_hs);
    int   bl_eff, last_beat, j, cycles, cmds, acks;
    bit   done, dropped, cmd_done;
    logic bry, rval, wrdy, exp_err, exp_lack;
    bl_eff    = (bl == 10'd0) ? 1 : int'(bl);
    last_beat = bl_eff - 1;
    if (err_beat >= 0 && err_beat < last_beat) last_beat = err_beat;
    if (tid_beat >= 0 && tid_beat < last_beat) last_beat = tid_beat;
    cycles = 0; cmds = 0; cmd_done = 0;
    while (!cmd_done && cycles < 100) begin
      bry  = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      wrdy = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'h0, bl, bry);
      wbc_bus.wbc_cmd_wrdy_i = wrdy;
      wbc_bus.wbc_res_rval_i = 1'b0;
      @(negedge clk_i);
      checkOutput("rd_cmd_noack", 64'(wbm_bus.wbm_ack_o), 64'd0);
      if (wbc_bus.wbc_cmd_val_o) begin
        checkOutput("rd_cmd_we", 64'(wbc_bus.wbc_cmd_we_o), 64'd0);
        checkOutput("rd_cmd_adr", 64'(wbc_bus.wbc_cmd_adr_o), 64'(adr));
        checkOutput("rd_cmd_bl", 64'(wbc_bus.wbc_cmd_bl_o), 64'(bl_eff));
        checkOutput("rd_cmd_tid", 64'(wbc_bus.wbc_cmd_tid_o), 64'(TID));
        if (wrdy) begin
          cmds++;
          cmd_done = 1;
        end
      end
      step_cycle();
      cycles++;
    end
    if (!cmd_done) checkOutput("rd_cmd_timeout", 64'd1, 64'd0);
    j = 0; acks = 0; done = 0; dropped = 0; cycles = 0;
    while (cmd_done && !done && cycles < 400) begin
      if (!dropped && drop_after > 0 && j == drop_after) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 10'h0, 1'b0);
        wbc_bus.wbc_res_rval_i = 1'b0;
        @(negedge clk_i);
        checkOutput("drop_noack", 64'(wbm_bus.wbm_ack_o), 64'd0);
        step_cycle();
        cycles++;
        dropped = 1;
        continue;
      end
      rval = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (dropped) begin
        // A new write request is presented while draining; it must be held off.
        bry = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, DRAIN_ADR, $urandom, 4'hF, 10'd1, 1'b1);
      end else begin
        bry = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'h0, bl, bry);
      end
      wbc_bus.wbc_cmd_wrdy_i = 1'($urandom_range(0, 1));
      wbc_bus.wbc_res_rval_i = rval;
      wbc_bus.wbc_res_dat_i  = base + 32'(j);
      wbc_bus.wbc_res_lack_i = (j == bl_eff - 1);
      wbc_bus.wbc_res_err_i  = (j == err_beat);
      wbc_bus.wbc_res_tid_i  = (j == tid_beat) ? 4'(TID + 4'd1) : TID;
      @(negedge clk_i);
      checkOutput("rd_rrdy", 64'(wbc_bus.wbc_res_rrdy_o), 64'(bry));
      checkOutput("rd_no_cmd", 64'(wbc_bus.wbc_cmd_val_o), 64'd0);
      if (rval && bry) begin
        if (dropped) begin
          checkOutput("drain_noack", 64'(wbm_bus.wbm_ack_o), 64'd0);
          if (j == bl_eff - 1) done = 1;
        end else begin
          exp_err  = (j == err_beat) || (j == tid_beat);
          exp_lack = (j == bl_eff - 1) || exp_err;
          checkOutput("rd_ack", 64'(wbm_bus.wbm_ack_o), 64'd1);
          checkOutput("rd_dat", 64'(wbm_bus.wbm_dat_o), 64'(base + 32'(j)));
          checkOutput("rd_err", 64'(wbm_bus.wbm_err_o), 64'(exp_err));
          checkOutput("rd_lack", 64'(wbm_bus.wbm_lack_o), 64'(exp_lack));
          acks++;
          if (exp_lack) done = 1;
        end
        j++;
      end else begin
        checkOutput("rd_idle_ack", 64'(wbm_bus.wbm_ack_o), 64'd0);
      end
      step_cycle();
      cycles++;
    end
    if (!done) checkOutput("rd_timeout", 64'd1, 64'd0);
    if (!dropped) checkOutput("rd_acks", 64'(acks), 64'(last_beat + 1));
    checkOutput("rd_cmds", 64'(cmds), 64'd1);
    idle_bus();
    @(negedge clk_i);
    check_quiet("rd_end");
    step_cycle();
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_bus();
    #2;
    check_quiet("reset_idle");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234, 32'h55, 4'hF, 10'd1, 1'b1);
    wbc_bus.wbc_cmd_wrdy_i = 1'b1;
    #1;
    check_quiet("reset_req");
    idle_bus();
    @(negedge clk_i);
    rst_n = 1'b1;
    step_cycle();

    // Single write, 4-beat write with stall on beat 2, 8-beat read with toggling bry.
    do_write(32'h0000_1000, 10'd1, 0, -1, 0);
    do_write(32'h0000_2000, 10'd4, 2, 1, 0);
    do_read(32'h0000_3000, 10'd8, 32'h0, -1, -1, 0, 1'b1);
    // Error on beat 3, then a normal transaction.
    do_read(32'h0000_4000, 10'd8, 32'h100, 2, -1, 0, 1'b0);
    do_write(32'h0000_4100, 10'd2, 0, -1, 0);
    // Foreign transaction ID.
    do_read(32'h0000_5000, 10'd4, 32'h200, -1, 1, 0, 1'b0);
    // Master abandons a read after 2 beats; the held-off write follows.
    do_read(32'h0000_6000, 10'd8, 32'h300, -1, -1, 2, 1'b1);
    do_write(DRAIN_ADR, 10'd1, 0, -1, 0);
    // Write abort after 2 beats, then a fresh single write.
    do_write(32'h0000_7000, 10'd4, 0, -1, 2);
    do_write(32'h0000_7100, 10'd1, 0, -1, 0);
    // Zero burst count behaves as one beat.
    do_write(32'h0000_8000, 10'd0, 0, -1, 0);
    do_read(32'h0000_8100, 10'd0, 32'h400, -1, -1, 0, 1'b0);

    // Asynchronous reset in the middle of a write burst.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_A000, 32'hCAFE, 4'hF, 10'd4, 1'b1);
    wbc_bus.wbc_cmd_wrdy_i = 1'b1;
    step_cycle();
    step_cycle();
    #1;
    checkOutput("rst_pre_val", 64'(wbc_bus.wbc_cmd_val_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_async");
    idle_bus();
    @(negedge clk_i);
    rst_n = 1'b1;
    step_cycle();
    do_read(32'h0000_9000, 10'd1, 32'h500, -1, -1, 0, 1'b0);

    // Randomized mix of reads and writes.
    for (int n = 0; n < 40; n++) begin
      logic [9:0]  rbl;
      logic [31:0] radr;
      int          beff, eb;
      rbl  = 10'($urandom_range(0, 9));
      radr = $urandom & 32'hFFFF_FFFC;
      beff = (rbl == 10'd0) ? 1 : int'(rbl);
      if ($urandom_range(0, 1) == 0) begin
        do_write(radr, rbl, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
      end else begin
        eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, beff - 1)) : -1;
        do_read(radr, rbl, $urandom, eb, -1, 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
